// File: rtl/cache_request_arbiter_if.sv
// Requester-side and cache-FSM-side signals of the cache request arbiter.
// master = the arbiter, slave = requesters plus cache FSM.
interface cache_request_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STAT_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          resp_hit;
  logic                          resp_err;
  logic                          cache_read_request;
  logic                          cache_write_request;
  logic [ADDR_WIDTH-1:0]         cache_address;
  logic [DATA_WIDTH-1:0]         cache_write_data;
  logic                          cache_ready;
  logic                          cache_hit_signal;
  logic                          cache_miss_signal;
  logic [DATA_WIDTH-1:0]         cache_read_data;
  logic [STAT_WIDTH-1:0]         hit_count;
  logic [STAT_WIDTH-1:0]         miss_count;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  cache_ready, cache_hit_signal, cache_miss_signal, cache_read_data,
    output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    output cache_read_request, cache_write_request, cache_address, cache_write_data,
    output hit_count, miss_count
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output cache_ready, cache_hit_signal, cache_miss_signal, cache_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
    input  cache_read_request, cache_write_request, cache_address, cache_write_data,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_request_arbiter.sv
// Round-robin share of one cache FSM between NUM_REQ requesters, one transaction in flight.
// Accept -> 1-cycle ISSUE pulse -> WAIT for hit/miss or watchdog -> routed 1-cycle response.
module cache_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int STAT_WIDTH     = 16
) (
  input logic                     clk,
  input logic                     reset_n,
  cache_request_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rr_ptr, grant_id, win_id;
  logic                  win_vld;
  logic [NUM_REQ-1:0]    ready;
  logic                  accept, done, timeout;
  logic [WD_W-1:0]       wdog;
  logic                  miss_flag;
  logic                  rd_req, wr_req;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NUM_REQ-1:0]    resp_vld;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  hit_q, err_q;
  logic [STAT_WIDTH-1:0] hit_cnt, miss_cnt;

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int k);
    int i;
    i = int'(base) + k;
    if (i >= NUM_REQ) i = i - NUM_REQ;
    return PTR_W'(i);
  endfunction

  // Scan from the farthest offset down so the nearest valid index at/after rr_ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot_idx(rr_ptr, k)]) begin
        win_vld = 1'b1;
        win_id  = rot_idx(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = '0;
    accept    = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld && bus.cache_ready) begin
          accept        = 1'b1;
          ready[win_id] = 1'b1;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.cache_hit_signal) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (wdog == WD_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      wdog      <= '0;
      miss_flag <= 1'b0;
      resp_vld  <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      resp_vld <= '0;
      if (accept) begin
        grant_id <= win_id;
        rr_ptr   <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
        addr_q   <= bus.req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q  <= bus.req_wdata[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
        rd_req   <= ~bus.req_write[win_id];
        wr_req   <= bus.req_write[win_id];
      end
      if (state == S_ISSUE) begin
        wdog      <= '0;
        miss_flag <= 1'b0;
      end
      if (state == S_WAIT) begin
        wdog <= wdog + 1'b1;
        if (bus.cache_miss_signal) miss_flag <= 1'b1;
      end
      // A miss reported in the completing cycle still marks the transaction as missed.
      if (done) begin
        resp_vld[grant_id] <= 1'b1;
        rdata_q            <= bus.cache_read_data;
        hit_q              <= ~(miss_flag | bus.cache_miss_signal);
        err_q              <= 1'b0;
        if (miss_flag | bus.cache_miss_signal) begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end else begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end
      end
      if (timeout) begin
        resp_vld[grant_id] <= 1'b1;
        rdata_q            <= '0;
        hit_q              <= 1'b0;
        err_q              <= 1'b1;
      end
    end
  end

  assign bus.req_ready           = ready;
  assign bus.resp_valid          = resp_vld;
  assign bus.resp_rdata          = rdata_q;
  assign bus.resp_hit            = hit_q;
  assign bus.resp_err            = err_q;
  assign bus.cache_read_request  = rd_req;
  assign bus.cache_write_request = wr_req;
  assign bus.cache_address       = addr_q;
  assign bus.cache_write_data    = wdata_q;
  assign bus.hit_count           = hit_cnt;
  assign bus.miss_count          = miss_cnt;
endmodule

// File: tb/tb_cache_request_arbiter.sv
// Bench for cache_request_arbiter: directed table, hand sequences and random traffic
// against a cycle-counting transaction model with a scripted cache FSM.
module tb_cache_request_arbiter;
  localparam int N = 3, AW = 8, DW = 8, T = 10, SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam int HIT = 0, MISS = 1, DROP = 2;

  logic clk, reset_n;

  cache_request_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) bus();

  cache_request_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                          .TIMEOUT_CYCLES(T), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, hit_at = -1, miss_at = -1, mode = HIT;
  logic [DW-1:0] cdata = '0;
  bit stray = 0;

  logic [N-1:0] s_ready, s_resp;
  logic [DW-1:0] s_rdata;
  logic s_hit, s_err;

  // transaction-level model
  bit m_busy, m_wr, m_missed;
  int m_a, m_id, m_rr, m_hc, m_mc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit p_vld, p_hit, p_err;
  int p_id;
  logic [DW-1:0] p_rdata, h_rdata;
  bit h_hit, h_err;

  typedef struct {
    int id; bit wr; logic [7:0] addr; logic [7:0] wdata; int mode; logic [7:0] cdata;
    int lat; int ehit; int eerr; logic [7:0] erd; int hc; int mc;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_missed = 0; m_a = 0; m_id = 0; m_rr = 0; m_hc = 0; m_mc = 0;
    m_addr = '0; m_wdata = '0; p_vld = 0; p_hit = 0; p_err = 0; p_id = 0; p_rdata = '0;
    h_rdata = '0; h_hit = 0; h_err = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] exp_resp, exp_ready;
    int w, k;
    exp_resp = '0;
    if (p_vld) begin
      exp_resp[p_id] = 1'b1;
      h_rdata = p_rdata; h_hit = p_hit; h_err = p_err;
      if (!p_err) begin
        if (p_hit) m_hc = (m_hc == SMAX) ? SMAX : m_hc + 1;
        else       m_mc = (m_mc == SMAX) ? SMAX : m_mc + 1;
      end
      p_vld = 0;
    end
    w = -1;
    if (!m_busy && bus.cache_ready === 1'b1)
      for (int j = 0; j < N; j++)
        if (w < 0 && bus.req_valid[(m_rr + j) % N]) w = (m_rr + j) % N;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", bus.req_ready, exp_ready);
    chk("read_request", bus.cache_read_request, m_busy && cyc == m_a + 1 && !m_wr);
    chk("write_request", bus.cache_write_request, m_busy && cyc == m_a + 1 && m_wr);
    chk("resp_valid", bus.resp_valid, exp_resp);
    chk("resp_rdata", bus.resp_rdata, h_rdata);
    chk("resp_hit", bus.resp_hit, h_hit);
    chk("resp_err", bus.resp_err, h_err);
    chk("cache_address", bus.cache_address, m_addr);
    chk("cache_write_data", bus.cache_write_data, m_wdata);
    chk("hit_count", bus.hit_count, m_hc);
    chk("miss_count", bus.miss_count, m_mc);
    if (m_busy) begin
      k = cyc - (m_a + 2);
      if (k >= 0) begin
        if (bus.cache_miss_signal) m_missed = 1;
        if (bus.cache_hit_signal) begin
          p_vld = 1; p_id = m_id; p_rdata = bus.cache_read_data; p_hit = !m_missed; p_err = 0;
          m_busy = 0;
        end else if (k == T - 1) begin
          p_vld = 1; p_id = m_id; p_rdata = '0; p_hit = 0; p_err = 1;
          m_busy = 0;
        end
      end
    end
    if (w >= 0) begin
      m_busy = 1; m_a = cyc; m_id = w; m_wr = bus.req_write[w]; m_missed = 0;
      m_addr = bus.req_addr[w*AW +: AW]; m_wdata = bus.req_wdata[w*DW +: DW];
      m_rr = (w + 1) % N;
    end
  endtask

  // One clock cycle: drive cache FSM pulses, sample, check, schedule replies.
  task automatic cycle();
    bus.cache_hit_signal  = (cyc == hit_at)  || (stray && $urandom_range(0, 24) == 0);
    bus.cache_miss_signal = (cyc == miss_at) || (stray && $urandom_range(0, 24) == 0);
    bus.cache_read_data   = cdata;
    #1;
    s_ready = bus.req_ready; s_resp = bus.resp_valid;
    s_rdata = bus.resp_rdata; s_hit = bus.resp_hit; s_err = bus.resp_err;
    model_step();
    if (bus.cache_read_request || bus.cache_write_request) begin
      if (mode == HIT)       begin hit_at = cyc + 4; miss_at = -1; end
      else if (mode == MISS) begin miss_at = cyc + 2; hit_at = cyc + 5; end
      else                   begin hit_at = -1; miss_at = -1; end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.cache_hit_signal = 1'b0; bus.cache_miss_signal = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_hit", bus.resp_hit, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_read_request", bus.cache_read_request, 0);
    chk("rst_write_request", bus.cache_write_request, 0);
    chk("rst_cache_address", bus.cache_address, 0);
    chk("rst_cache_write_data", bus.cache_write_data, 0);
    chk("rst_hit_count", bus.hit_count, 0);
    chk("rst_miss_count", bus.miss_count, 0);
    model_reset();
    hit_at = -1; miss_at = -1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic issue(input int id, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       output int acc, output bit ok);
    bus.req_valid[id] = 1'b1; bus.req_write[id] = wr;
    bus.req_addr[id*AW +: AW] = a; bus.req_wdata[id*DW +: DW] = d;
    ok = 0; acc = -1;
    for (int i = 0; i < 30 && !ok; i++) begin
      acc = cyc;
      cycle();
      if (s_ready[id]) ok = 1;
    end
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output int rc, output bit ok);
    ok = 0; rc = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      rc = cyc;
      cycle();
      if (s_resp != 0) ok = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int acc, rc, n, bad;
    bit ok;
    int grants [3];

    tbl[0] = '{0, 0, 8'h35, 8'h00, HIT,  8'h5A, 6,     1, 0, 8'h5A, 1, 0};
    tbl[1] = '{1, 1, 8'h12, 8'hC3, MISS, 8'h77, 7,     0, 0, 8'h77, 1, 1};
    tbl[2] = '{2, 0, 8'hA0, 8'h9C, DROP, 8'hAA, T + 2, 0, 1, 8'h00, 1, 1};
    tbl[3] = '{0, 1, 8'hFF, 8'h01, HIT,  8'h11, 6,     1, 0, 8'h11, 2, 1};
    tbl[4] = '{2, 0, 8'h00, 8'h3E, MISS, 8'hEE, 7,     0, 0, 8'hEE, 2, 2};

    reset_n = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.cache_ready = 1'b1; bus.cache_hit_signal = 1'b0; bus.cache_miss_signal = 1'b0;
    bus.cache_read_data = '0;
    #1;
    apply_reset();

    // directed single transactions
    for (int r = 0; r < 5; r++) begin
      mode = tbl[r].mode; cdata = tbl[r].cdata;
      issue(tbl[r].id, tbl[r].wr, tbl[r].addr, tbl[r].wdata, acc, ok);
      chk("tbl_accept", ok, 1);
      wait_resp(rc, ok);
      chk("tbl_resp_seen", ok, 1);
      chk("tbl_latency", rc - acc, tbl[r].lat);
      chk("tbl_resp_port", s_resp, 1 << tbl[r].id);
      chk("tbl_rdata", s_rdata, tbl[r].erd);
      chk("tbl_hit", s_hit, tbl[r].ehit);
      chk("tbl_err", s_err, tbl[r].eerr);
      chk("tbl_hit_count", bus.hit_count, tbl[r].hc);
      chk("tbl_miss_count", bus.miss_count, tbl[r].mc);
    end

    // timeout, then next grant must wait for cache_ready
    mode = DROP;
    issue(2, 0, 8'h44, 8'h00, acc, ok);
    bus.cache_ready = 1'b0;
    bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b0; bus.req_addr[0*AW +: AW] = 8'h21;
    wait_resp(rc, ok);
    chk("t4_timeout_latency", rc - acc, T + 2);
    chk("t4_err", s_err, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin cycle(); if (s_ready != 0) bad++; end
    chk("t4_no_grant_without_ready", bad, 0);
    bus.cache_ready = 1'b1;
    cycle();
    chk("t4_grant_after_ready", s_ready, 3'b001);
    bus.req_valid[0] = 1'b0;
    mode = HIT; cdata = 8'h42;
    wait_resp(rc, ok);
    chk("t4_followup_resp", s_resp, 3'b001);

    // saturation of the hit counter
    for (int i = 0; i < (1 << SW) + 2; i++) begin
      issue(0, 0, 8'(i), 8'h00, acc, ok);
      wait_resp(rc, ok);
    end
    chk("t5_hit_count_sat", bus.hit_count, SMAX);

    // round robin between two always-valid requesters
    apply_reset();
    mode = HIT;
    bus.req_valid = 3'b011; bus.req_addr = 24'h000201;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      cycle();
      for (int j = 0; j < N; j++) if (s_ready[j] && n < 3) begin grants[n] = j; n++; end
    end
    chk("t2_grant_count", n, 3);
    chk("t2_grant0", grants[0], 0);
    chk("t2_grant1", grants[1], 1);
    chk("t2_grant2", grants[2], 0);
    bus.req_valid = '0;
    for (int i = 0; i < 12; i++) cycle();

    // random traffic
    stray = 1;
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        if (s_ready[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_write[i] = 1'($urandom);
          bus.req_addr[i*AW +: AW] = 8'($urandom);
          bus.req_wdata[i*DW +: DW] = 8'($urandom);
        end
      end
      bus.cache_ready = ($urandom_range(0, 3) != 0);
      n = $urandom_range(0, 9);
      mode = (n < 5) ? HIT : (n < 8) ? MISS : DROP;
      cdata = 8'($urandom);
      cycle();
    end
    stray = 0;
    bus.req_valid = '0; bus.cache_ready = 1'b1;
    for (int i = 0; i < T + 8; i++) cycle();

    // reset in WAIT
    mode = HIT;
    issue(1, 0, 8'h66, 8'h00, acc, ok);
    cycle(); cycle(); cycle();
    #3;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 15; i++) begin cycle(); if (s_resp != 0) bad++; end
    chk("t6_no_resp_after_reset", bad, 0);
    bus.req_valid = 3'b111;
    cycle();
    chk("t6_rr_ptr_zero", s_ready, 3'b001);
    bus.req_valid = '0;
    for (int i = 0; i < 10; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
